// File: rtl/sprite_arb_pkg.sv
// Shared types and widths for the sprite RAM arbiter.
package sprite_arb_pkg;

  localparam int SPRITE_ADDR_W = 8;
  localparam int SPRITE_DATA_W = 24;
  localparam int STARVE_CNT_W  = 8;

  typedef enum logic [1:0] {CL_NONE, CL_DRAW, CL_HIT, CL_LD} client_e;

endpackage

// File: rtl/sprite_arb_starve_ctr.sv
// Sampler wait counter: counts ungranted request cycles and saturates at STARVE_MAX.
module sprite_arb_starve_ctr
  import sprite_arb_pkg::*;
#(
  parameter int STARVE_MAX = 16
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    hit_req_i,
  input  logic                    hit_gnt_i,
  input  logic                    draw_req_i,
  input  logic                    locked_i,
  output logic                    starve_o,
  output logic                    break_o,
  output logic [STARVE_CNT_W-1:0] wait_cnt_o
);

  localparam logic [STARVE_CNT_W-1:0] CNT_MAX = STARVE_CNT_W'(STARVE_MAX);

  logic [STARVE_CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!hit_req_i || hit_gnt_i) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != CNT_MAX) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Draw always wins, so the guard only forces a grant in a draw-free cycle.
  assign starve_o   = hit_req_i && !draw_req_i && (wait_cnt_q == CNT_MAX);
  assign break_o    = starve_o && locked_i;
  assign wait_cnt_o = wait_cnt_q;

endmodule

// File: rtl/sprite_ram_arbiter.sv
// Three-client arbiter for the single-port sprite RAM: draw > round-robin(hit, ld),
// with a loader burst lock bounded by the sampler starvation guard.
module sprite_ram_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int ADDR_W     = SPRITE_ADDR_W,
  parameter int DATA_W     = SPRITE_DATA_W,
  parameter int STARVE_MAX = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              draw_req,
  input  logic [ADDR_W-1:0] draw_addr,
  output logic              draw_gnt,
  output logic              draw_valid,
  output logic [DATA_W-1:0] draw_data,
  input  logic              hit_req,
  input  logic [ADDR_W-1:0] hit_addr,
  output logic              hit_gnt,
  output logic              hit_valid,
  output logic [DATA_W-1:0] hit_data,
  input  logic              ld_req,
  input  logic              ld_lock,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_gnt,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              starve_break
);

  client_e                 sel;
  logic                    starve;
  logic [STARVE_CNT_W-1:0] wait_cnt;

  logic              rr_ld_q, rr_ld_d;
  logic              locked_q, locked_d;
  logic [ADDR_W-1:0] addr_q;
  logic              draw_valid_q, hit_valid_q;

  sprite_arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .hit_req_i (hit_req),
    .hit_gnt_i (hit_gnt),
    .draw_req_i(draw_req),
    .locked_i  (locked_q),
    .starve_o  (starve),
    .break_o   (starve_break),
    .wait_cnt_o(wait_cnt)
  );

  always_comb begin
    sel = CL_NONE;
    if (draw_req) begin
      sel = CL_DRAW;
    end else if (starve) begin
      sel = CL_HIT;
    end else if (locked_q) begin
      if (ld_req) sel = CL_LD;
    end else if (hit_req && ld_req) begin
      sel = rr_ld_q ? CL_LD : CL_HIT;
    end else if (hit_req) begin
      sel = CL_HIT;
    end else if (ld_req) begin
      sel = CL_LD;
    end
  end

  assign draw_gnt = (sel == CL_DRAW);
  assign hit_gnt  = (sel == CL_HIT);
  assign ld_gnt   = (sel == CL_LD);

  // Idle cycles replay the last address so the RAM address bus stays quiet.
  always_comb begin
    case (sel)
      CL_DRAW: ram_addr = draw_addr;
      CL_HIT:  ram_addr = hit_addr;
      CL_LD:   ram_addr = ld_addr;
      default: ram_addr = addr_q;
    endcase
  end

  assign ram_we    = ld_gnt;
  assign ram_wdata = ld_data;

  always_comb begin
    rr_ld_d = rr_ld_q;
    if (hit_gnt)     rr_ld_d = 1'b1;
    else if (ld_gnt) rr_ld_d = 1'b0;
  end

  // A draw preemption is neither an ld grant nor an ld_req drop, so the lock survives it.
  always_comb begin
    locked_d = locked_q;
    if (ld_gnt)       locked_d = ld_lock;
    else if (!ld_req) locked_d = 1'b0;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rr_ld_q      <= 1'b0;
      locked_q     <= 1'b0;
      addr_q       <= '0;
      draw_valid_q <= 1'b0;
      hit_valid_q  <= 1'b0;
    end else begin
      rr_ld_q      <= rr_ld_d;
      locked_q     <= locked_d;
      addr_q       <= ram_addr;
      draw_valid_q <= draw_gnt;
      hit_valid_q  <= hit_gnt;
    end
  end

  assign draw_valid = draw_valid_q;
  assign hit_valid  = hit_valid_q;
  assign draw_data  = ram_rdata;
  assign hit_data   = ram_rdata;

endmodule
